// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM with a mem_req/mem_ready handshake, memory-wait timeout,
// R-type funct decode, bne/addi support, a sticky illegal-op fault state and a retire counter.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_toreg,
  output logic [3:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_IEXEC  = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
  localparam logic [3:0] S_FAULT  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // The wait counter never exceeds MEM_TIMEOUT-1, the last non-ready cycle before a fault.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  logic [3:0]        r_state;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [CNT_W-1:0]  r_count;
  logic              r_fault;

  logic [3:0] w_nextState;
  logic       w_memState;
  logic       w_timeout;
  logic       w_retire;
  logic       w_functOk;
  logic [2:0] w_functOp;

  logic       w_memReq;
  logic       w_memWrite;
  logic       w_iOrD;
  logic       w_irWrite;
  logic       w_pcWrite;
  logic [1:0] w_pcSrc;
  logic       w_aluSrcA;
  logic [1:0] w_aluSrcB;
  logic [2:0] w_aluOp;
  logic       w_regWrite;
  logic       w_regDst;
  logic       w_memToReg;

  assign w_memState = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout  = (MEM_TIMEOUT != 0) && w_memState && !mem_ready && (r_waitCnt == WAIT_LAST);
  assign w_retire   = (w_nextState == S_FETCH) && (r_state != S_FETCH);

  always_comb begin
    w_functOk = 1'b1;
    w_functOp = ALU_ADD;
    case (funct)
      6'b100000: w_functOp = ALU_ADD;
      6'b100010: w_functOp = ALU_SUB;
      6'b100100: w_functOp = ALU_AND;
      6'b100101: w_functOp = ALU_OR;
      6'b101010: w_functOp = ALU_SLT;
      default:   w_functOk = 1'b0;
    endcase
  end

  // A completing transfer takes priority over the timeout in the same cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_nextState = S_DECODE;
        else if (w_timeout) w_nextState = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_nextState = S_EXEC;
          OP_LW, OP_SW: w_nextState = S_MEMADR;
          OP_BEQ, OP_BNE: w_nextState = S_BRANCH;
          OP_J:         w_nextState = S_JUMP;
          OP_ADDI:      w_nextState = S_IEXEC;
          default:      w_nextState = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      w_nextState = S_MEMRD;
        else if (opcode == OP_SW) w_nextState = S_MEMWR;
        else                      w_nextState = S_FAULT;
      end
      S_MEMRD: begin
        if (mem_ready)      w_nextState = S_MEMWB;
        else if (w_timeout) w_nextState = S_FAULT;
      end
      S_MEMWR: begin
        if (mem_ready)      w_nextState = S_FETCH;
        else if (w_timeout) w_nextState = S_FAULT;
      end
      S_EXEC:   w_nextState = w_functOk ? S_RWB : S_FAULT;
      S_IEXEC:  w_nextState = S_IWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: w_nextState = S_FETCH;
      S_FAULT:  w_nextState = S_FAULT;
      default:  w_nextState = S_FAULT;
    endcase
  end

  always_comb begin
    w_memReq   = 1'b0;
    w_memWrite = 1'b0;
    w_iOrD     = 1'b0;
    w_irWrite  = 1'b0;
    w_pcWrite  = 1'b0;
    w_pcSrc    = 2'b00;
    w_aluSrcA  = 1'b0;
    w_aluSrcB  = 2'b00;
    w_aluOp    = ALU_ADD;
    w_regWrite = 1'b0;
    w_regDst   = 1'b0;
    w_memToReg = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memReq  = 1'b1;
        w_aluSrcB = 2'b01;
        w_irWrite = mem_ready;
        w_pcWrite = mem_ready;
      end
      S_DECODE: w_aluSrcB = 2'b11;
      S_MEMADR: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = 2'b10;
      end
      S_MEMRD: begin
        w_memReq = 1'b1;
        w_iOrD   = 1'b1;
      end
      S_MEMWB: begin
        w_regWrite = 1'b1;
        w_memToReg = 1'b1;
      end
      S_MEMWR: begin
        w_memReq   = 1'b1;
        w_memWrite = 1'b1;
        w_iOrD     = 1'b1;
      end
      S_EXEC: begin
        w_aluSrcA = 1'b1;
        w_aluOp   = w_functOp;
      end
      S_RWB: begin
        w_regWrite = 1'b1;
        w_regDst   = 1'b1;
      end
      S_BRANCH: begin
        w_aluSrcA = 1'b1;
        w_aluOp   = ALU_SUB;
        w_pcSrc   = 2'b01;
        w_pcWrite = (opcode == OP_BNE) ? !zero : zero;
      end
      S_JUMP: begin
        w_pcWrite = 1'b1;
        w_pcSrc   = 2'b10;
      end
      S_IEXEC: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = 2'b10;
      end
      S_IWB: w_regWrite = 1'b1;
      default: ;
    endcase
  end

  // Wait counter restarts on every state change, so entry to a memory state always sees zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_waitCnt <= '0;
      r_count   <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState != r_state)
        r_waitCnt <= '0;
      else if (w_memState && !mem_ready)
        r_waitCnt <= r_waitCnt + WAIT_W'(1);
      if (w_retire)
        r_count <= r_count + CNT_W'(1);
      if (w_nextState == S_FAULT)
        r_fault <= 1'b1;
    end
  end

  assign mem_req     = w_memReq   && reset;
  assign mem_write   = w_memWrite && reset;
  assign ir_write    = w_irWrite  && reset;
  assign pc_write    = w_pcWrite  && reset;
  assign reg_write   = w_regWrite && reset;
  assign i_or_d      = w_iOrD;
  assign pc_src      = w_pcSrc;
  assign alu_src_a   = w_aluSrcA;
  assign alu_src_b   = w_aluSrcB;
  assign alu_op      = w_aluOp;
  assign reg_dst     = w_regDst;
  assign mem_toreg   = w_memToReg;
  assign state       = r_state;
  assign fault       = r_fault;
  assign instr_count = r_count;

endmodule
